// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a small byte FIFO.
// Bytes written while o_Tx_Ready is high are queued. The FSM pops the head
// byte whenever it is idle and something is queued, then serialises it
// LSB first. Every output driven by the FSM is a register, so the line
// can only change on a clock edge and never glitches.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic                          i_Tx_DV,
    input  logic [7:0]                    i_Tx_Byte,
    output logic                          o_Tx_Ready,
    output logic                          o_Tx_Serial,
    output logic                          o_Tx_Active,
    output logic                          o_Tx_Done,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);

    localparam int          AW         = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [15:0] CLK_LAST   = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_BIT = 3'd1,
        DATA_BITS = 3'd2,
        STOP_BIT  = 3'd3,
        CLEANUP   = 3'd4
    } state_t;

    state_t          state;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [7:0]      shift_reg;
    logic [2:0]      bit_index;
    logic [15:0]     clk_count;
    logic            write_accept;
    logic            pop;

    // A write is only taken when there is room; the pop happens in the single
    // IDLE cycle in which the FSM loads the shift register.
    assign write_accept = i_Tx_DV && (count != FULL_COUNT);
    assign pop          = (state == IDLE) && (count != '0);
    assign o_Tx_Ready   = (count != FULL_COUNT);
    assign o_Fifo_Count = count;

    // Store accepted bytes; storage needs no reset because count gates reads.
    always_ff @(posedge i_Clock) begin
        if (write_accept && !i_Reset) begin
            mem[wr_ptr] <= i_Tx_Byte;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (write_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({write_accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Frame sequencer: each output is loaded together with the state change so
    // every bit occupies the line for exactly CLKS_PER_BIT cycles.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state       <= IDLE;
            o_Tx_Serial <= 1'b1;
            o_Tx_Active <= 1'b0;
            o_Tx_Done   <= 1'b0;
            clk_count   <= '0;
            bit_index   <= '0;
            shift_reg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    o_Tx_Serial <= 1'b1;
                    o_Tx_Active <= 1'b0;
                    o_Tx_Done   <= 1'b0;
                    clk_count   <= '0;
                    bit_index   <= '0;
                    if (pop) begin
                        shift_reg   <= mem[rd_ptr];
                        o_Tx_Serial <= 1'b0;
                        o_Tx_Active <= 1'b1;
                        state       <= START_BIT;
                    end
                end
                START_BIT: begin
                    if (clk_count == CLK_LAST) begin
                        clk_count   <= '0;
                        bit_index   <= '0;
                        o_Tx_Serial <= shift_reg[0];
                        state       <= DATA_BITS;
                    end else begin
                        clk_count <= clk_count + 16'd1;
                    end
                end
                DATA_BITS: begin
                    if (clk_count == CLK_LAST) begin
                        clk_count <= '0;
                        if (bit_index == 3'd7) begin
                            o_Tx_Serial <= 1'b1;
                            state       <= STOP_BIT;
                        end else begin
                            bit_index   <= bit_index + 3'd1;
                            o_Tx_Serial <= shift_reg[bit_index + 3'd1];
                        end
                    end else begin
                        clk_count <= clk_count + 16'd1;
                    end
                end
                STOP_BIT: begin
                    if (clk_count == CLK_LAST) begin
                        clk_count   <= '0;
                        o_Tx_Active <= 1'b0;
                        o_Tx_Done   <= 1'b1;
                        state       <= CLEANUP;
                    end else begin
                        clk_count <= clk_count + 16'd1;
                    end
                end
                CLEANUP: begin
                    o_Tx_Done <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    o_Tx_Serial <= 1'b1;
                    o_Tx_Active <= 1'b0;
                    o_Tx_Done   <= 1'b0;
                    clk_count   <= '0;
                    bit_index   <= '0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A behavioural mid-bit sampling receiver decodes the line independently.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clock;
    logic       reset;
    logic       txDv;
    logic [7:0] txByte;
    logic       txReady;
    logic       txSerial;
    logic       txActive;
    logic       txDone;
    logic [2:0] fifoCount;

    int checks   = 0;
    int failures = 0;
    int doneCount = 0;
    logic [7:0] rxQ [$];

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .i_Clock      (clock),
        .i_Reset      (reset),
        .i_Tx_DV      (txDv),
        .i_Tx_Byte    (txByte),
        .o_Tx_Ready   (txReady),
        .o_Tx_Serial  (txSerial),
        .o_Tx_Active  (txActive),
        .o_Tx_Done    (txDone),
        .o_Fifo_Count (fifoCount)
    );

    // Free-running clock, 10 time units per cycle.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count Done pulses, sampled mid-cycle.
    always @(negedge clock) begin
        if (txDone === 1'b1) doneCount++;
    end

    // Independent UART receiver: find a start bit, sample each bit at its middle.
    initial begin
        logic [7:0] rxByte;
        rxByte = '0;
        forever begin
            @(negedge clock);
            if (reset === 1'b1 || txSerial !== 1'b0) continue;
            repeat (CPB / 2) @(negedge clock);
            if (txSerial !== 1'b0) continue;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clock);
                rxByte[i] = txSerial;
            end
            repeat (CPB) @(negedge clock);
            if (txSerial === 1'b1) rxQ.push_back(rxByte);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic dv, input logic [7:0] b);
        txDv   = dv;
        txByte = b;
        tick();
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Starting on the first start-bit cycle, check every line cycle of one frame,
    // finishing on the CLEANUP cycle.
    task automatic checkFrame(input logic [7:0] b, input string tag);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < CPB; c++) begin
                checkOutput({tag, "_serial"}, {7'd0, txSerial}, {7'd0, bits[i]});
                if (c == 0) begin
                    checkOutput({tag, "_active"}, {7'd0, txActive}, 8'd1);
                    checkOutput({tag, "_doneLow"}, {7'd0, txDone}, 8'd0);
                end
                tick();
            end
        end
        checkOutput({tag, "_donePulse"}, {7'd0, txDone}, 8'd1);
        checkOutput({tag, "_cleanupActive"}, {7'd0, txActive}, 8'd0);
        checkOutput({tag, "_cleanupSerial"}, {7'd0, txSerial}, 8'd1);
    endtask

    initial begin
        int rxBase;
        int doneBase;
        int lowCycles;
        logic [7:0] expBytes [8];

        reset  = 1'b1;
        txDv   = 1'b0;
        txByte = 8'h00;
        repeat (3) tick();

        // Reset values
        checkOutput("rst_serial", {7'd0, txSerial}, 8'd1);
        checkOutput("rst_active", {7'd0, txActive}, 8'd0);
        checkOutput("rst_done",   {7'd0, txDone},   8'd0);
        checkOutput("rst_count",  {5'd0, fifoCount}, 8'd0);
        checkOutput("rst_ready",  {7'd0, txReady},  8'd1);
        reset = 1'b0;
        tick();
        checkOutput("rel_serial", {7'd0, txSerial}, 8'd1);

        // Single byte 0x61: count 1 at cycle 1, start bit at cycle 2, Done at 42
        doneBase = doneCount;
        applyStimulus(1'b1, 8'h61);
        txDv = 1'b0;
        checkOutput("t1_count1", {5'd0, fifoCount}, 8'd1);
        checkOutput("t1_idleSerial", {7'd0, txSerial}, 8'd1);
        tick();
        checkOutput("t1_count0", {5'd0, fifoCount}, 8'd0);
        checkFrame(8'h61, "t1");
        tick();
        checkOutput("t1_afterDone", {7'd0, txDone}, 8'd0);
        checkOutput("t1_afterSerial", {7'd0, txSerial}, 8'd1);
        repeat (4) tick();
        checkOutput("t1_doneCount", 8'(doneCount - doneBase), 8'd1);

        // Back-to-back 0xA5, 0x3C: second start two cycles after the first stop bit
        doneBase = doneCount;
        applyStimulus(1'b1, 8'hA5);
        applyStimulus(1'b1, 8'h3C);
        txDv = 1'b0;
        checkOutput("t2_countWrPop", {5'd0, fifoCount}, 8'd1);
        checkFrame(8'hA5, "t2a");
        tick();
        checkOutput("t2_gapSerial", {7'd0, txSerial}, 8'd1);
        checkOutput("t2_gapActive", {7'd0, txActive}, 8'd0);
        tick();
        checkFrame(8'h3C, "t2b");
        repeat (4) tick();
        checkOutput("t2_doneCount", 8'(doneCount - doneBase), 8'd2);
        checkOutput("t2_countEnd", {5'd0, fifoCount}, 8'd0);

        // Six writes from idle: one popped, four fill the FIFO, sixth dropped
        rxBase   = rxQ.size();
        doneBase = doneCount;
        for (int i = 0; i < 6; i++) begin
            checkOutput("t3_ready", {7'd0, txReady}, (i < 5) ? 8'd1 : 8'd0);
            applyStimulus(1'b1, 8'(8'h10 + i));
        end
        txDv = 1'b0;
        checkOutput("t3_countFull", {5'd0, fifoCount}, 8'd4);
        checkOutput("t3_readyFull", {7'd0, txReady}, 8'd0);
        repeat (350) tick();
        checkOutput("t3_frames", 8'(rxQ.size() - rxBase), 8'd5);
        checkOutput("t3_doneCount", 8'(doneCount - doneBase), 8'd5);
        for (int i = 0; i < 5; i++) begin
            expBytes[i] = 8'(8'h10 + i);
            checkOutput("t3_byte", rxQ[rxBase + i], expBytes[i]);
        end

        // Reset during DATA_BITS with three bytes queued
        applyStimulus(1'b1, 8'h81);
        applyStimulus(1'b1, 8'h82);
        applyStimulus(1'b1, 8'h83);
        applyStimulus(1'b1, 8'h84);
        txDv = 1'b0;
        repeat (6) tick();
        checkOutput("t4_activePre", {7'd0, txActive}, 8'd1);
        checkOutput("t4_countPre", {5'd0, fifoCount}, 8'd3);
        doneBase = doneCount;
        reset = 1'b1;
        applyStimulus(1'b1, 8'h99);
        reset = 1'b0;
        txDv  = 1'b0;
        checkOutput("t4_serial", {7'd0, txSerial}, 8'd1);
        checkOutput("t4_active", {7'd0, txActive}, 8'd0);
        checkOutput("t4_count", {5'd0, fifoCount}, 8'd0);
        checkOutput("t4_ready", {7'd0, txReady}, 8'd1);
        lowCycles = 0;
        for (int i = 0; i < 100; i++) begin
            if (txSerial !== 1'b1) lowCycles++;
            tick();
        end
        checkOutput("t4_lineLow", 8'(lowCycles), 8'd0);
        checkOutput("t4_doneCount", 8'(doneCount - doneBase), 8'd0);
        checkOutput("t4_countEnd", {5'd0, fifoCount}, 8'd0);

        // Write and pop in the same cycle with count 2; order preserved
        rxBase = rxQ.size();
        applyStimulus(1'b1, 8'hC0);
        txDv = 1'b0;
        tick();
        applyStimulus(1'b1, 8'hC1);
        applyStimulus(1'b1, 8'hC2);
        txDv = 1'b0;
        for (int i = 0; i < 100 && txDone !== 1'b1; i++) tick();
        checkOutput("t5_doneSeen", {7'd0, txDone}, 8'd1);
        tick();
        checkOutput("t5_countBefore", {5'd0, fifoCount}, 8'd2);
        applyStimulus(1'b1, 8'hC3);
        txDv = 1'b0;
        checkOutput("t5_countAfter", {5'd0, fifoCount}, 8'd2);
        checkOutput("t5_startSerial", {7'd0, txSerial}, 8'd0);
        repeat (200) tick();
        expBytes[0] = 8'hC0;
        expBytes[1] = 8'hC1;
        expBytes[2] = 8'hC2;
        expBytes[3] = 8'hC3;
        checkOutput("t5_frames", 8'(rxQ.size() - rxBase), 8'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t5_order", rxQ[rxBase + i], expBytes[i]);
        end

        // Loopback of boundary patterns
        rxBase   = rxQ.size();
        doneBase = doneCount;
        applyStimulus(1'b1, 8'h00);
        applyStimulus(1'b1, 8'hFF);
        applyStimulus(1'b1, 8'h55);
        txDv = 1'b0;
        repeat (200) tick();
        expBytes[0] = 8'h00;
        expBytes[1] = 8'hFF;
        expBytes[2] = 8'h55;
        checkOutput("t6_frames", 8'(rxQ.size() - rxBase), 8'd3);
        checkOutput("t6_doneCount", 8'(doneCount - doneBase), 8'd3);
        for (int i = 0; i < 3; i++) begin
            checkOutput("t6_byte", rxQ[rxBase + i], expBytes[i]);
        end
        checkOutput("t6_idleSerial", {7'd0, txSerial}, 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10416, meaning clocks per bit (100 MHz / 9600 baud); legal range 4..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning transmit FIFO entries; legal values are powers of 2 from 2 to 256.
REQ-003 SHALL have port i_Clock, input, 1 bit: system clock; all logic is rising-edge.
REQ-004 SHALL have port i_Reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port i_Tx_DV, input, 1 bit: write strobe for i_Tx_Byte.
REQ-006 SHALL have port i_Tx_Byte, input, 8 bits: byte to queue.
REQ-007 SHALL have port o_Tx_Ready, output, 1 bit: FIFO not full; a write is accepted only when this is 1.
REQ-008 SHALL have port o_Tx_Serial, output, 1 bit: registered UART line; idle high.
REQ-009 SHALL have port o_Tx_Active, output, 1 bit: high while a frame is on the line.
REQ-010 SHALL have port o_Tx_Done, output, 1 bit: 1-clock pulse after each frame's stop bit.
REQ-011 SHALL have port o_Fifo_Count, output, log2(FIFO_DEPTH)+1 bits: bytes queued, excluding the byte in flight.

Function
REQ-012 SHALL transmit 8N1 frames: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit lasts exactly CLKS_PER_BIT cycles.
REQ-013 SHALL accept a write when i_Tx_DV=1 and o_Tx_Ready=1; the byte is counted in o_Fifo_Count on the next cycle.
REQ-014 SHALL ignore a write when full (o_Tx_Ready=0); FIFO contents and count are unchanged and no error is flagged.
REQ-015 SHALL keep the count unchanged on a simultaneous accepted write and pop; the FIFO wraps its pointers modulo FIFO_DEPTH.
REQ-016 SHALL implement FSM states IDLE, START_BIT, DATA_BITS, STOP_BIT, CLEANUP.
REQ-017 IDLE: o_Tx_Serial=1, o_Tx_Active=0; if the registered count is >0, pop the head byte into a shift register and go to START_BIT.
REQ-018 START_BIT: o_Tx_Serial=0, o_Tx_Active=1 for CLKS_PER_BIT cycles, then go to DATA_BITS with bit index 0.
REQ-019 DATA_BITS: o_Tx_Serial=byte[index] for CLKS_PER_BIT cycles per bit; after index 7 completes, go to STOP_BIT.
REQ-020 STOP_BIT: o_Tx_Serial=1 for CLKS_PER_BIT cycles, then go to CLEANUP.
REQ-021 CLEANUP: o_Tx_Done=1 and o_Tx_Active=0 for one cycle, then go to IDLE.
REQ-022 Latency: a write at cycle t into an empty FIFO with the FSM in IDLE SHALL cause a pop at t+1 and o_Tx_Serial=0 from t+2.
REQ-023 Back-to-back: with the FIFO non-empty, the next start bit SHALL begin exactly 2 cycles after the last stop-bit cycle (CLEANUP, then IDLE pop).
REQ-024 SHALL not change the popped byte mid-frame when new writes arrive.
REQ-025 SHALL use a bit counter of at least 16 bits with no overflow for any legal CLKS_PER_BIT.
REQ-026 Unreachable state encodings SHALL return to IDLE with o_Tx_Serial=1.

Reset
REQ-027 While i_Reset=1 at a clock edge, the block SHALL set the state to IDLE, o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Fifo_Count=0, o_Tx_Ready=1, and clear the pointers and counters.
REQ-028 Reset mid-frame SHALL abort the frame (line high the next cycle) and flush all queued bytes; writes during reset are ignored.
REQ-029 o_Tx_Serial SHALL never glitch low as a result of reset release.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-030 Single byte 0x61 written at cycle 0 -> o_Tx_Serial from cycle 2 is 0, then 1,0,0,0,0,1,1,0, then 1, each 4 cycles wide; o_Tx_Done pulses at cycle 42.
REQ-031 Bytes 0xA5 and 0x3C written on consecutive cycles -> two complete frames; the second start bit begins 2 cycles after the first stop bit ends; 2 Done pulses.
REQ-032 Six writes while the FSM is in IDLE -> the first is popped; the next 4 fill the FIFO; o_Tx_Ready=0; the sixth is dropped; exactly 5 frames are sent.
REQ-033 Reset asserted during DATA_BITS with 3 bytes queued -> line high the next cycle, count 0, no further frames, no Done pulse.
REQ-034 Write and pop in the same cycle with count 2 -> count stays 2; byte order is preserved.
REQ-035 Loopback into the existing uart_rx with the same CLKS_PER_BIT for bytes 0x00, 0xFF, 0x55 -> the receiver reports identical bytes, each with one o_Rx_DV pulse.
